// File: rtl/tone_dec_pkg.sv
// Shared constants for the tone decoder: note codes, 50 MHz reference periods, FSM states.
package tone_dec_pkg;

    localparam int NOTE_W    = 4;
    localparam int NUM_NOTES = 8;

    localparam logic [NOTE_W-1:0] NOTE_NONE = 4'd0;
    localparam logic [NOTE_W-1:0] NOTE_C4   = 4'd1;
    localparam logic [NOTE_W-1:0] NOTE_D4   = 4'd2;
    localparam logic [NOTE_W-1:0] NOTE_E4   = 4'd3;
    localparam logic [NOTE_W-1:0] NOTE_F4   = 4'd4;
    localparam logic [NOTE_W-1:0] NOTE_G4   = 4'd5;
    localparam logic [NOTE_W-1:0] NOTE_A4   = 4'd6;
    localparam logic [NOTE_W-1:0] NOTE_B4   = 4'd7;
    localparam logic [NOTE_W-1:0] NOTE_C5   = 4'd8;

    // Full square-wave periods in 50 MHz cycles, index 0 = C4 .. 7 = C5
    localparam int REF_PERIOD [NUM_NOTES] = '{191110, 170265, 151685, 143172,
                                              127551, 113636, 101239, 95557};

    typedef enum logic [1:0] {IDLE, ARMED, TRACK} state_t;

endpackage

// File: rtl/tone_edge_sync.sv
// Two-flop synchronizer for the asynchronous tone line plus a one-cycle rising-edge pulse.
module tone_edge_sync
    import tone_dec_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic edge_p
);

    logic sync1;
    logic sync2;
    logic sync2_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
        end else begin
            sync1   <= din;
            sync2   <= sync1;
            sync2_d <= sync2;
        end
    end

    assign edge_p = sync2 & ~sync2_d;

endmodule

// File: rtl/tone_decoder.sv
// Measures the speaker square-wave period and decodes it to a note index with a stability filter.
// Optional TONE_DEC_DEVIATION_EN adds a sharp/flat indication port (dev).
module tone_decoder
    import tone_dec_pkg::*;
#(
    parameter int PERIOD_W   = 20,
    parameter int TOL_SHIFT  = 6,
    parameter int STABLE_CNT = 3,
    parameter int GLITCH_CYC = 16,
    parameter int REF_SHIFT  = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tone_in,
    output logic [NOTE_W-1:0]   note,
    output logic                note_valid,
    output logic                note_change,
    output logic [PERIOD_W-1:0] period
`ifdef TONE_DEC_DEVIATION_EN
    ,
    output logic [1:0]          dev
`endif
);

    localparam logic [PERIOD_W-1:0] CNT_MAX  = '1;
    localparam int                  MCNT_W   = $clog2(STABLE_CNT + 1);
    localparam logic [MCNT_W-1:0]   MCNT_MAX = MCNT_W'(STABLE_CNT);

    logic                edge_p;
    logic                acc;
    logic                timeout;
    logic [PERIOD_W-1:0] cnt;
    state_t              state;
    logic                cap_stb;
    logic                cls_stb;
    logic [NOTE_W-1:0]   cls;
    logic [NOTE_W-1:0]   cand;
    logic [NOTE_W-1:0]   cand_nxt;
    logic [MCNT_W-1:0]   mcnt;
    logic [MCNT_W-1:0]   mcnt_nxt;
    logic                note_upd;
    logic [NOTE_W-1:0]   note_nxt;

    // Lowest matching note wins; REF_SHIFT scales the table for faster clocks or simulation.
    function automatic logic [NOTE_W-1:0] classify(input logic [PERIOD_W-1:0] p);
        logic [NOTE_W-1:0]       res;
        logic [PERIOD_W-1:0]     ref_v;
        logic signed [PERIOD_W:0] diff;
        logic [PERIOD_W:0]       mag;
        res = NOTE_NONE;
        for (int i = NUM_NOTES - 1; i >= 0; i--) begin
            ref_v = PERIOD_W'(REF_PERIOD[i] >> REF_SHIFT);
            diff  = $signed({1'b0, p}) - $signed({1'b0, ref_v});
            mag   = diff[PERIOD_W] ? $unsigned(-diff) : $unsigned(diff);
            if (mag <= {1'b0, ref_v >> TOL_SHIFT}) begin
                res = NOTE_C4 + NOTE_W'(i);
            end
        end
        return res;
    endfunction

    tone_edge_sync u_sync (
        .clk    (clk),
        .reset  (reset),
        .din    (tone_in),
        .edge_p (edge_p)
    );

    assign acc        = edge_p && ((state == IDLE) || (cnt >= PERIOD_W'(GLITCH_CYC)));
    assign timeout    = (state != IDLE) && !acc && (cnt == CNT_MAX);
    assign note_valid = (note != NOTE_NONE);

    always_comb begin
        cand_nxt = cand;
        mcnt_nxt = mcnt;
        if (cls == cand) begin
            if (mcnt != MCNT_MAX) begin
                mcnt_nxt = mcnt + 1'b1;
            end
        end else begin
            cand_nxt = cls;
            mcnt_nxt = MCNT_W'(1);
        end
        note_upd = (cls_stb && (mcnt_nxt == MCNT_MAX) && (cand_nxt != note))
                || (timeout && (note != NOTE_NONE));
        note_nxt = timeout ? NOTE_NONE : cand_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (acc) begin
            cnt <= PERIOD_W'(1);
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            period      <= '0;
            cap_stb     <= 1'b0;
            cls_stb     <= 1'b0;
            cls         <= NOTE_NONE;
            cand        <= NOTE_NONE;
            mcnt        <= '0;
            note        <= NOTE_NONE;
            note_change <= 1'b0;
        end else begin
            cap_stb     <= 1'b0;
            cls_stb     <= cap_stb;
            note_change <= 1'b0;
            if (cap_stb) begin
                cls <= classify(period);
            end
            if (cls_stb) begin
                cand <= cand_nxt;
                mcnt <= mcnt_nxt;
            end
            case (state)
                IDLE: begin
                    if (acc) begin
                        state <= ARMED;
                    end
                end
                ARMED, TRACK: begin
                    // A saturated count that coincides with an edge is captured, not timed out
                    if (acc) begin
                        period  <= cnt;
                        cap_stb <= 1'b1;
                        state   <= TRACK;
                    end else if (timeout) begin
                        state  <= IDLE;
                        period <= '0;
                        cand   <= NOTE_NONE;
                        mcnt   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
            if (note_upd) begin
                note        <= note_nxt;
                note_change <= 1'b1;
            end
        end
    end

`ifdef TONE_DEC_DEVIATION_EN
    function automatic logic [1:0] dev_of(input logic [NOTE_W-1:0] n,
                                          input logic [PERIOD_W-1:0] p);
        logic [PERIOD_W-1:0] ref_v;
        logic [PERIOD_W-1:0] dlt;
        logic [1:0]          res;
        res = 2'b00;
        if (n != NOTE_NONE) begin
            ref_v = PERIOD_W'(REF_PERIOD[int'(n) - 1] >> REF_SHIFT);
            dlt   = ref_v >> 8;
            if ({1'b0, p} < ({1'b0, ref_v} - {1'b0, dlt})) begin
                res = 2'b01;
            end else if ({1'b0, p} > ({1'b0, ref_v} + {1'b0, dlt})) begin
                res = 2'b10;
            end
        end
        return res;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dev <= 2'b00;
        end else if (note_upd) begin
            dev <= dev_of(note_nxt, period);
        end
    end
`else
    // note alone carries the decode result; no deviation comparators
`endif

endmodule
